// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: round-robin arbiter and strobe sequencer for the shared LC-3 SRAM bus.
// Define MEM_ACCESS_CTRL_STATS_EN to build the per-requester completed-access counters.
module mem_access_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    inout  wire  [DATA_W-1:0] Data,
    output logic [15:0]       cpu_cnt,
    output logic [15:0]       dbg_cnt
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYC - 1);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              grant_dbg;
    logic              last_dbg;
    logic              lat_we;
    logic              drive_en;
    logic [DATA_W-1:0] lat_wdata;

    logic              pick_dbg;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Debug wins when it is the only requester, or on contention when the CPU had the last grant.
    assign pick_dbg  = dbg_req && (!cpu_req || !last_dbg);
    assign sel_we    = pick_dbg ? dbg_we    : cpu_we;
    assign sel_addr  = pick_dbg ? dbg_addr  : cpu_addr;
    assign sel_wdata = pick_dbg ? dbg_wdata : cpu_wdata;

    assign Data = drive_en ? lat_wdata : 'z;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            grant_dbg <= 1'b0;
            last_dbg  <= 1'b1;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            drive_en  <= 1'b0;
            mem_addr  <= '0;
            mem_ce_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_we_n  <= 1'b1;
            cpu_ready <= 1'b0;
            dbg_ready <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req || dbg_req) begin
                        state     <= ACCESS;
                        wait_cnt  <= '0;
                        grant_dbg <= pick_dbg;
                        lat_we    <= sel_we;
                        lat_wdata <= sel_wdata;
                        mem_addr  <= sel_addr;
                        mem_ce_n  <= 1'b0;
                        mem_oe_n  <= sel_we;
                        mem_we_n  <= !sel_we;
                        drive_en  <= sel_we;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == LAST_WAIT) begin
                        state    <= DONE;
                        mem_ce_n <= 1'b1;
                        mem_oe_n <= 1'b1;
                        mem_we_n <= 1'b1;
                        if (!lat_we && grant_dbg)
                            dbg_rdata <= Data;
                        if (!lat_we && !grant_dbg)
                            cpu_rdata <= Data;
                        dbg_ready <= grant_dbg;
                        cpu_ready <= !grant_dbg;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                DONE: begin
                    // Write data stays on the bus through DONE as a one-cycle hold.
                    state     <= IDLE;
                    drive_en  <= 1'b0;
                    cpu_ready <= 1'b0;
                    dbg_ready <= 1'b0;
                    last_dbg  <= grant_dbg;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ACCESS_CTRL_STATS_EN
    // Saturating completion counters, bumped once per DONE of the granted requester.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cpu_cnt <= '0;
            dbg_cnt <= '0;
        end else if (state == DONE) begin
            if (!grant_dbg && cpu_cnt != 16'hFFFF)
                cpu_cnt <= cpu_cnt + 16'd1;
            if (grant_dbg && dbg_cnt != 16'hFFFF)
                dbg_cnt <= dbg_cnt + 16'd1;
        end
    end
`else
    assign cpu_cnt = '0;
    assign dbg_cnt = '0;
`endif

endmodule
